// File: rtl/matrix_frame_ctrl.sv
// matrix_frame_ctrl
// Double-buffered row scanner for an 8x8 LED matrix. Each row gets a slot made
// of a short blanking phase followed by a lit phase. Rows are written into a
// back buffer, and a commit publishes that buffer at the next frame boundary.
// Publishing only swaps the front/back roles; no data is copied.

module matrix_frame_ctrl #(
   parameter int DWELL    = 27000,
   parameter int BLANK    = 16,
   parameter int NUM_ROWS = 8
) (
   input  logic       sys_clock,
   input  logic       sys_rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       commit,
   output logic       commit_pending,
   output logic [2:0] row,
   output logic [7:0] col,
   output logic       frame_start
);

   // The phase counter only needs to reach the longer of the two phase lengths.
   localparam int MAX_PHASE = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
   localparam logic [2:0]       LAST_ROW   = 3'(NUM_ROWS - 1);
   localparam logic [3:0]       ROW_LIMIT  = 4'(NUM_ROWS);

   typedef enum logic {
      ST_BLANK,
      ST_LIT
   } scan_state_t;

   scan_state_t      state;
   scan_state_t      state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]       row_next;
   logic [7:0]       col_next;
   logic             frame_start_next;
   logic             boundary;

   // scan_run is clear after reset. The first edge after release starts a
   // clean row-0 blanking phase and raises frame_start.
   logic             scan_run;

   logic             front_sel;
   logic [7:0]       frame_buf [2][8];
   logic [7:0]       front_row;
   logic             wr_accept;
   logic             wr_in_range;
   logic             swap;

   assign front_row   = frame_buf[front_sel][row];
   assign wr_ready    = ~commit_pending;
   assign wr_accept   = wr_valid & wr_ready;
   assign wr_in_range = ({1'b0, wr_row} < ROW_LIMIT);
   assign swap        = boundary & commit_pending;

   // Next scan state. The column value is computed here so that the column
   // register switches on the same edge as the FSM state and the row.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt + 1'b1;
      row_next         = row;
      col_next         = 8'h00;
      frame_start_next = 1'b0;
      boundary         = 1'b0;
      if (!scan_run) begin
         state_next       = ST_BLANK;
         cnt_next         = '0;
         row_next         = 3'd0;
         frame_start_next = 1'b1;
      end else begin
         case (state)
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_next = ST_LIT;
                  cnt_next   = '0;
                  col_next   = front_row;
               end
            end
            ST_LIT: begin
               col_next = front_row;
               if (cnt == DWELL_LAST) begin
                  state_next = ST_BLANK;
                  cnt_next   = '0;
                  col_next   = 8'h00;
                  if (row == LAST_ROW) begin
                     row_next         = 3'd0;
                     frame_start_next = 1'b1;
                     boundary         = 1'b1;
                  end else begin
                     row_next = row + 3'd1;
                  end
               end
            end
            default: begin
               state_next = ST_BLANK;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Scan state, row and column registers.
   always_ff @(posedge sys_clock) begin
      if (!sys_rst_n) begin
         state       <= ST_BLANK;
         cnt         <= '0;
         row         <= 3'd0;
         col         <= 8'h00;
         frame_start <= 1'b0;
         scan_run    <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         row         <= row_next;
         col         <= col_next;
         frame_start <= frame_start_next;
         scan_run    <= 1'b1;
      end
   end

   // Commit handshake and the front index. A swap needs commit_pending to be
   // set before the boundary edge. A commit that arrives in the boundary
   // cycle only arms the swap for the following frame.
   always_ff @(posedge sys_clock) begin
      if (!sys_rst_n) begin
         commit_pending <= 1'b0;
         front_sel      <= 1'b0;
      end else if (swap) begin
         commit_pending <= 1'b0;
         front_sel      <= ~front_sel;
      end else if (commit && !commit_pending) begin
         commit_pending <= 1'b1;
      end
   end

   // Back-buffer writes. They are blocked while a commit is pending because
   // wr_ready is low then. Writes to rows outside the scanned range are
   // accepted but dropped.
   always_ff @(posedge sys_clock) begin
      if (!sys_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               frame_buf[b][r] <= 8'h00;
            end
         end
      end else if (wr_accept && wr_in_range) begin
         frame_buf[~front_sel][wr_row] <= wr_data;
      end
   end

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// tb_matrix_frame_ctrl
// Directed bench for matrix_frame_ctrl. It runs an 8-row instance and a
// 4-row instance (DWELL=4, BLANK=2) from one clock, and keeps a small
// front/back buffer shadow to derive the expected column values.

module tb_matrix_frame_ctrl;

   localparam int DW    = 4;
   localparam int BL    = 2;
   localparam int SLOT  = DW + BL;
   localparam int FRAME = 8 * SLOT;
   localparam int SFRAME = 4 * SLOT;

   logic       sys_clock = 1'b0;
   logic       sys_rst_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       commit;
   logic       commit_pending;
   logic [2:0] row;
   logic [7:0] col;
   logic       frame_start;

   logic       s_rst_n;
   logic       s_wr_valid;
   logic       s_wr_ready;
   logic [2:0] s_wr_row;
   logic [7:0] s_wr_data;
   logic       s_commit;
   logic       s_commit_pending;
   logic [2:0] s_row;
   logic [7:0] s_col;
   logic       s_frame_start;

   int         checks = 0;
   int         errors = 0;
   int         pos    = 0;
   int         spos   = 0;
   logic [7:0] m_front [8];
   logic [7:0] m_back  [8];

   always #5 sys_clock = ~sys_clock;

   matrix_frame_ctrl #(.DWELL(DW), .BLANK(BL), .NUM_ROWS(8)) dut (
      .sys_clock      (sys_clock),
      .sys_rst_n      (sys_rst_n),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_row         (wr_row),
      .wr_data        (wr_data),
      .commit         (commit),
      .commit_pending (commit_pending),
      .row            (row),
      .col            (col),
      .frame_start    (frame_start)
   );

   matrix_frame_ctrl #(.DWELL(DW), .BLANK(BL), .NUM_ROWS(4)) dut4 (
      .sys_clock      (sys_clock),
      .sys_rst_n      (s_rst_n),
      .wr_valid       (s_wr_valid),
      .wr_ready       (s_wr_ready),
      .wr_row         (s_wr_row),
      .wr_data        (s_wr_data),
      .commit         (s_commit),
      .commit_pending (s_commit_pending),
      .row            (s_row),
      .col            (s_col),
      .frame_start    (s_frame_start)
   );

   // Expected column at frame position p for the shadowed front buffer.
   function automatic logic [7:0] exp_col(input int p);
      if ((p % SLOT) >= BL) return m_front[p / SLOT];
      return 8'h00;
   endfunction

   task automatic tick();
      @(posedge sys_clock);
      #1;
      pos  = (pos + 1) % FRAME;
      spos = (spos + 1) % SFRAME;
   endtask

   task automatic model_swap();
      logic [7:0] t;
      for (int i = 0; i < 8; i++) begin
         t          = m_front[i];
         m_front[i] = m_back[i];
         m_back[i]  = t;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_front[i] = 8'h00;
         m_back[i]  = 8'h00;
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      tick();
      tick();
      checks++; if (row !== 3'd0) begin errors++; $display("[TB] FAIL reset_row got=%0d exp=0", row); end
      checks++; if (col !== 8'h00) begin errors++; $display("[TB] FAIL reset_col got=%h exp=00", col); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got=%b exp=0", commit_pending); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready got=%b exp=1", wr_ready); end
      sys_rst_n = 1'b1;
      tick();
      pos = 0;
      checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL release_frame_start got=%b exp=1", frame_start); end
   endtask

   task automatic test_idle_scan();
      for (int i = 0; i < 2 * FRAME; i++) begin
         checks++; if (col !== 8'h00) begin errors++; $display("[TB] FAIL idle_col pos=%0d got=%h exp=00", pos, col); end
         checks++; if (row !== 3'(pos / SLOT)) begin errors++; $display("[TB] FAIL idle_row pos=%0d got=%0d exp=%0d", pos, row, pos / SLOT); end
         checks++; if (frame_start !== (pos == 0)) begin errors++; $display("[TB] FAIL idle_frame_start pos=%0d got=%b exp=%b", pos, frame_start, pos == 0); end
         tick();
      end
   endtask

   task automatic test_write_commit();
      repeat (10) tick();
      wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL wc_ready_before got=%b exp=1", wr_ready); end
      tick();
      m_back[3] = 8'hA5;
      wr_valid = 1'b0; commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < FRAME - 12; i++) begin
         checks++; if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL wc_pending pos=%0d got=%b exp=1", pos, commit_pending); end
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL wc_ready pos=%0d got=%b exp=0", pos, wr_ready); end
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL wc_old_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
      model_swap();
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL wc_pending_clear got=%b exp=0", commit_pending); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL wc_ready_after got=%b exp=1", wr_ready); end
      for (int i = 0; i < FRAME; i++) begin
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL wc_new_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
   endtask

   task automatic test_held_write();
      repeat (5) tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      wr_valid = 1'b1; wr_row = 3'd2; wr_data = 8'h3C;
      for (int i = 0; i < FRAME - 6; i++) begin
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL hw_ready pos=%0d got=%b exp=0", pos, wr_ready); end
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL hw_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
      model_swap();
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL hw_ready_swap got=%b exp=1", wr_ready); end
      tick();
      m_back[2] = 8'h3C;
      wr_valid = 1'b0;
      for (int i = 0; i < FRAME - 1; i++) begin
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL hw_hidden_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
      commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (FRAME - 1) tick();
      model_swap();
      for (int i = 0; i < FRAME; i++) begin
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL hw_shown_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
   endtask

   task automatic test_boundary_commit();
      repeat (FRAME - 1) tick();
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL bc_idle_pending got=%b exp=0", commit_pending); end
      commit = 1'b1;
      tick();
      commit = 1'b0;
      checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL bc_frame_start got=%b exp=1", frame_start); end
      for (int i = 0; i < FRAME; i++) begin
         checks++; if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL bc_pending pos=%0d got=%b exp=1", pos, commit_pending); end
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL bc_deferred_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
      model_swap();
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL bc_pending_clear got=%b exp=0", commit_pending); end
      for (int i = 0; i < FRAME; i++) begin
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL bc_swapped_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      wr_valid = 1'b1; wr_row = 3'd5; wr_data = 8'hFF;
      tick();
      m_back[5] = 8'hFF;
      wr_valid = 1'b0; commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (FRAME - 2) tick();
      model_swap();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (32) tick();
      checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL mr_lit_col pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL mr_pending got=%b exp=1", commit_pending); end
      sys_rst_n = 1'b0;
      tick();
      model_clear();
      checks++; if (row !== 3'd0) begin errors++; $display("[TB] FAIL mr_row got=%0d exp=0", row); end
      checks++; if (col !== 8'h00) begin errors++; $display("[TB] FAIL mr_col got=%h exp=00", col); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL mr_pending_clear got=%b exp=0", commit_pending); end
      sys_rst_n = 1'b1;
      tick();
      pos = 0;
      checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL mr_frame_start got=%b exp=1", frame_start); end
      for (int i = 0; i < FRAME; i++) begin
         checks++; if (col !== exp_col(pos)) begin errors++; $display("[TB] FAIL mr_blank_frame pos=%0d got=%h exp=%h", pos, col, exp_col(pos)); end
         tick();
      end
   endtask

   task automatic test_num_rows4();
      logic [7:0] e;
      s_rst_n = 1'b1;
      tick();
      spos = 0;
      checks++; if (s_frame_start !== 1'b1) begin errors++; $display("[TB] FAIL r4_frame_start got=%b exp=1", s_frame_start); end
      s_wr_valid = 1'b1; s_wr_row = 3'd5; s_wr_data = 8'hFF;
      checks++; if (s_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL r4_ready got=%b exp=1", s_wr_ready); end
      tick();
      s_wr_valid = 1'b0; s_commit = 1'b1;
      tick();
      s_commit = 1'b0;
      checks++; if (s_commit_pending !== 1'b1) begin errors++; $display("[TB] FAIL r4_pending got=%b exp=1", s_commit_pending); end
      repeat (SFRAME - 2) tick();
      checks++; if (s_commit_pending !== 1'b0) begin errors++; $display("[TB] FAIL r4_pending_clear got=%b exp=0", s_commit_pending); end
      for (int i = 0; i < 2 * SFRAME; i++) begin
         checks++; if (s_col !== 8'h00) begin errors++; $display("[TB] FAIL r4_col pos=%0d got=%h exp=00", spos, s_col); end
         checks++; if (s_row !== 3'(spos / SLOT)) begin errors++; $display("[TB] FAIL r4_row pos=%0d got=%0d exp=%0d", spos, s_row, spos / SLOT); end
         checks++; if (s_frame_start !== (spos == 0)) begin errors++; $display("[TB] FAIL r4_frame_start pos=%0d got=%b exp=%b", spos, s_frame_start, spos == 0); end
         tick();
      end
      s_wr_valid = 1'b1; s_wr_row = 3'd1; s_wr_data = 8'h81;
      tick();
      s_wr_valid = 1'b0; s_commit = 1'b1;
      tick();
      s_commit = 1'b0;
      repeat (SFRAME - 2) tick();
      for (int i = 0; i < SFRAME; i++) begin
         e = ((spos % SLOT) >= BL && (spos / SLOT) == 1) ? 8'h81 : 8'h00;
         checks++; if (s_col !== e) begin errors++; $display("[TB] FAIL r4_write_col pos=%0d got=%h exp=%h", spos, s_col, e); end
         tick();
      end
   endtask

   initial begin
      sys_rst_n = 1'b0; wr_valid = 1'b0; wr_row = 3'd0; wr_data = 8'h00; commit = 1'b0;
      s_rst_n = 1'b0; s_wr_valid = 1'b0; s_wr_row = 3'd0; s_wr_data = 8'h00; s_commit = 1'b0;
      model_clear();
      test_reset();
      test_idle_scan();
      test_write_commit();
      test_held_write();
      test_boundary_commit();
      test_mid_reset();
      test_num_rows4();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_frame_ctrl.md
MATRIX_FRAME_CTRL -- requirements
Module: matrix_frame_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 27000, cycles one row is lit per scan slot (>=1).
REQ-002 SHALL have parameter BLANK, default 16, cycles columns are forced off before each row is lit (>=1).
REQ-003 SHALL have parameter NUM_ROWS, default 8, rows scanned per frame (1..8).
REQ-004 SHALL have port sys_clock  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port wr_valid  in  1  row-write request.
REQ-007 SHALL have port wr_ready  out  1  row-write accept.
REQ-008 SHALL have port wr_row  in  3  target row index.
REQ-009 SHALL have port wr_data  in  8  column pattern for the target row.
REQ-010 SHALL have port commit  in  1  one-cycle request to publish the back buffer.
REQ-011 SHALL have port commit_pending  out  1  publish requested but not yet performed.
REQ-012 SHALL have port row  out  3  currently driven row index.
REQ-013 SHALL have port col  out  8  currently driven column pattern, 1 = LED on.
REQ-014 SHALL have port frame_start  out  1  one-cycle pulse at the start of each frame.

Function
REQ-015 SHALL hold two 8x8-bit frame buffers: front (scanned) and back (written); one index bit selects front.
REQ-016 SHALL sequence a two-state scan FSM per row: BLANK (col=0, BLANK cycles), then LIT (col=front[row], DWELL cycles).
REQ-017 SHALL advance row at the LIT->BLANK transition: row+1, or 0 when row = NUM_ROWS-1; row is constant within a slot.
REQ-018 SHALL give a frame period of exactly NUM_ROWS*(BLANK+DWELL) cycles with no idle cycles.
REQ-019 SHALL register col, so col changes on the same edge as the FSM state change, with no skew against row.
REQ-020 SHALL assert frame_start for exactly the first cycle of the row-0 BLANK phase.
REQ-021 SHALL accept a write when wr_valid & wr_ready, storing wr_data into back[wr_row] on that edge.
REQ-022 SHALL accept and silently drop writes with wr_row >= NUM_ROWS.
REQ-023 SHALL drive wr_ready = ~commit_pending; the back buffer is frozen while a commit is pending.
REQ-024 SHALL set commit_pending on commit when not already pending; commit while pending is ignored.
REQ-025 SHALL apply a write and a commit in the same cycle with the write first, so the write is included in the published frame.
REQ-026 SHALL swap buffers at the frame boundary (last-row LIT -> row-0 BLANK edge) only if commit_pending was already 1 before that edge.
REQ-027 SHALL, on that swap edge, toggle the front index, clear commit_pending and raise wr_ready.
REQ-028 SHALL, for a commit arriving in the boundary cycle itself, set pending only and defer the swap one frame.
REQ-029 SHALL perform no copy on swap; the new back buffer holds the previous front contents.
REQ-030 SHALL never display a partially updated frame; the front buffer changes only at a swap.

Reset
REQ-031 SHALL, while sys_rst_n=0 at a clock edge, set row=0, col=0, frame_start=0, commit_pending=0, wr_ready=1, FSM=BLANK with a zero cycle count, front index=0, and both buffers all-zero.
REQ-032 SHALL abort any slot or pending commit immediately on mid-operation reset; the first cycle after release is row-0 BLANK with frame_start=1.

Verification (DWELL=4, BLANK=2, NUM_ROWS=8, frame = 48 cycles)
REQ-033 SHALL verify idle after reset -> col=0 throughout; row steps 0..7 every 6 cycles; frame_start every 48 cycles, first one in the cycle after release.
REQ-034 SHALL verify a write of row 3=0xA5 followed by commit mid-frame -> commit_pending=1 and wr_ready=0 until the boundary; in the next frame col=0xA5 for the 4 LIT cycles of row 3 only, 0 elsewhere.
REQ-035 SHALL verify wr_valid held with row 2=0x3C while pending -> no acceptance until the swap edge; accepted in the first cycle with wr_ready=1; not visible until the following commit+boundary.
REQ-036 SHALL verify commit asserted in the final LIT cycle of row 7 -> no swap at that boundary; swap one frame later.
REQ-037 SHALL verify NUM_ROWS=4 with a write of wr_row=5 -> accepted, no buffer change; row wraps 3->0; frame = 24 cycles.
REQ-038 SHALL verify reset asserted during the row-5 LIT phase with a commit pending -> next cycle row=0, col=0, commit_pending=0; the displayed frame is all-zero.
